// File: rtl/wb_ram_bist_pkg.sv
// Shared types and defaults for the Wishbone RAM BIST initiator.
package wb_ram_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_GAP,
    S_RD_REQ,
    S_RD_GAP,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_CONST = 2'b00,
    MODE_ADDR  = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_INV   = 2'b11
  } mode_e;

  localparam logic [31:0] LFSR_POLY_DEF   = 32'h8020_0003;
  localparam int          TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/wb_bist_patgen.sv
// Pattern generator: the word for a given transfer index, with a Galois LFSR for MODE_LFSR.
module wb_bist_patgen
  import wb_ram_bist_pkg::*;
#(
  parameter int                   ADDRWIDTH = 9,
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] LFSR_POLY = DATAWIDTH'(LFSR_POLY_DEF)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  mode_e                mode_i,
  input  logic [DATAWIDTH-1:0] seed_i,
  input  logic [ADDRWIDTH:0]   idx_i,
  input  logic [ADDRWIDTH-1:0] addr_i,
  input  logic                 load_i,
  input  logic                 step_i,
  output logic [DATAWIDTH-1:0] data_o
);

  localparam int HALF = DATAWIDTH / 2;

  logic [DATAWIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATAWIDTH-1:0] seed_fix;
  logic [DATAWIDTH-1:0] lfsr_cur;
  logic [HALF-1:0]      addr_ext;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
  assign seed_fix = (seed_i == '0) ? DATAWIDTH'(1) : seed_i;
  // Index 0 always starts from the seed, so the read pass regenerates the write sequence.
  assign lfsr_cur = (idx_i == '0) ? seed_fix : lfsr_q;
  assign addr_ext = HALF'(addr_i);

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_fix;
    end else if (step_i) begin
      lfsr_d = {1'b0, lfsr_cur[DATAWIDTH-1:1]} ^ (lfsr_cur[0] ? LFSR_POLY : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= '0;
    else       lfsr_q <= lfsr_d;
  end

  always_comb begin
    data_o = seed_i;
    case (mode_i)
      MODE_CONST: data_o = seed_i;
      MODE_ADDR:  data_o = {~addr_ext, addr_ext};
      MODE_LFSR:  data_o = lfsr_cur;
      MODE_INV:   data_o = ~seed_i;
      default:    data_o = seed_i;
    endcase
  end

endmodule

// File: rtl/wb_ram_bist_master.sv
// Wishbone initiator that writes a pattern over a RAM word range, reads it back and compares.
module wb_ram_bist_master
  import wb_ram_bist_pkg::*;
#(
  parameter int                   ADDRWIDTH   = 9,
  parameter int                   DATAWIDTH   = 32,
  parameter int                   TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [DATAWIDTH-1:0] LFSR_POLY   = DATAWIDTH'(LFSR_POLY_DEF)
) (
  input  logic                   WBs_CLK_i,
  input  logic                   WBs_RST_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [DATAWIDTH-1:0]   seed_i,
  input  logic [ADDRWIDTH-1:0]   base_i,
  input  logic [ADDRWIDTH:0]     len_i,
  output logic [ADDRWIDTH+1:0]   WBm_ADR_o,
  output logic                   WBm_CYC_o,
  output logic                   WBm_STB_o,
  output logic                   WBm_WE_o,
  output logic [DATAWIDTH/8-1:0] WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0]   WBm_DAT_o,
  input  logic [DATAWIDTH-1:0]   WBm_DAT_i,
  input  logic                   WBm_ACK_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [9:0]             err_cnt_o,
  output logic [ADDRWIDTH-1:0]   first_err_addr_o
);

  localparam int WAITW = $clog2(TIMEOUT_CYC + 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [DATAWIDTH-1:0] seed_q, seed_d;
  logic [ADDRWIDTH-1:0] base_q, base_d;
  logic [ADDRWIDTH:0]   len_q, len_d;
  logic [ADDRWIDTH:0]   idx_q, idx_d;
  logic [WAITW-1:0]     wait_q, wait_d;
  logic [9:0]           err_cnt_q, err_cnt_d;
  logic [ADDRWIDTH-1:0] first_err_q, first_err_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;

  logic                 lfsr_load, lfsr_step;
  logic [DATAWIDTH-1:0] pat_data;
  logic [ADDRWIDTH-1:0] word_addr;
  logic                 in_req, in_cyc;

  assign word_addr = base_q + idx_q[ADDRWIDTH-1:0];

  wb_bist_patgen #(
    .ADDRWIDTH(ADDRWIDTH),
    .DATAWIDTH(DATAWIDTH),
    .LFSR_POLY(LFSR_POLY)
  ) u_patgen (
    .clk_i  (WBs_CLK_i),
    .rst_i  (WBs_RST_i),
    .mode_i (mode_q),
    .seed_i (seed_q),
    .idx_i  (idx_q),
    .addr_i (word_addr),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .data_o (pat_data)
  );

  // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d      = mode_e'(mode_i);
          seed_d      = seed_i;
          base_d      = base_i;
          len_d       = len_i;
          idx_d       = '0;
          wait_d      = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          lfsr_load   = 1'b1;
          state_d     = (len_i == '0) ? S_DONE : S_WR_REQ;
        end
      end
      S_WR_REQ, S_RD_REQ: begin
        // A late ACK in the expiring cycle still wins over the timeout.
        if (WBm_ACK_i) begin
          lfsr_step = 1'b1;
          idx_d     = idx_q + 1'b1;
          state_d   = (state_q == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
          if (state_q == S_RD_REQ && WBm_DAT_i != pat_data) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) first_err_d = word_addr;
          end
        end else if (wait_q == WAITW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WR_GAP: begin
        wait_d = '0;
        if (idx_q == len_q) begin
          idx_d     = '0;
          lfsr_load = 1'b1;
          state_d   = S_RD_REQ;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_RD_GAP: begin
        wait_d  = '0;
        state_d = (idx_q == len_q) ? S_DONE : S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Verdict is fixed on entry to DONE so it is valid alongside done_o.
    if (state_d == S_DONE && state_q != S_DONE) begin
      pass_d = (err_cnt_d == '0) && !timeout_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_CONST;
      seed_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign in_req = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign in_cyc = in_req || (state_q == S_WR_GAP) || (state_q == S_RD_GAP);

  assign WBm_CYC_o        = in_cyc;
  assign WBm_STB_o        = in_req;
  assign WBm_WE_o         = (state_q == S_WR_REQ);
  assign WBm_BYTE_STB_o   = in_req ? '1 : '0;
  assign WBm_DAT_o        = (state_q == S_WR_REQ) ? pat_data : '0;
  assign WBm_ADR_o        = in_cyc ? {2'b00, word_addr} : '0;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign timeout_o        = timeout_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// Bench for wb_ram_bist_master: 1-cycle-ACK RAM responder, trace monitor and pattern model.
module tb_wb_ram_bist_master;

  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] seed = '0;
  logic [8:0]  base = '0;
  logic [9:0]  len = '0;
  logic [10:0] adr;
  logic        cyc, stb, we;
  logic [3:0]  bstb;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0;
  logic        busy, done, pass, tmo;
  logic [9:0]  errc;
  logic [8:0]  ferr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_ram_bist_master dut (
    .WBs_CLK_i        (clk),
    .WBs_RST_i        (rst),
    .start_i          (start),
    .mode_i           (mode),
    .seed_i           (seed),
    .base_i           (base),
    .len_i            (len),
    .WBm_ADR_o        (adr),
    .WBm_CYC_o        (cyc),
    .WBm_STB_o        (stb),
    .WBm_WE_o         (we),
    .WBm_BYTE_STB_o   (bstb),
    .WBm_DAT_o        (dat_o),
    .WBm_DAT_i        (dat_i),
    .WBm_ACK_i        (ack),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .timeout_o        (tmo),
    .err_cnt_o        (errc),
    .first_err_addr_o (ferr)
  );

  // Responder: ACK one cycle after STB, gated on its own ACK; optional read corruption.
  logic [31:0] mem [512];
  bit          no_ack = 1'b0;
  bit          flip_en = 1'b0;
  logic [8:0]  flip_word = '0;

  always @(posedge clk) begin
    if (rst) begin
      ack <= 1'b0;
    end else if (cyc && stb && !ack && !no_ack) begin
      ack <= 1'b1;
      if (we) mem[adr[8:0]] <= dat_o;
      else    dat_i <= mem[adr[8:0]] ^ {31'b0, (flip_en && adr[8:0] == flip_word)};
    end else begin
      ack <= 1'b0;
    end
  end

  typedef struct {
    bit          we;
    logic [10:0] adr;
    logic [31:0] dat;
  } xfer_t;

  xfer_t trace[$];
  int    cyc_cnt = 0;
  int    proto_bad = 0;

  always @(negedge clk) begin
    xfer_t x;
    if (cyc && stb && ack) begin
      x.we  = we;
      x.adr = adr;
      x.dat = we ? dat_o : 32'h0;
      trace.push_back(x);
    end
    if (cyc) cyc_cnt++;
    if (bstb !== (stb ? 4'hF : 4'h0) || (stb && !cyc)) proto_bad++;
  end

  function automatic logic [31:0] model_pat(logic [1:0] m, logic [31:0] s, int idx, int word);
    logic [31:0] l;
    logic [15:0] w16;
    w16 = word[15:0];
    case (m)
      2'b00: return s;
      2'b01: return {~w16, w16};
      2'b10: begin
        l = (s == 0) ? 32'h1 : s;
        for (int k = 0; k < idx; k++) l = l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
        return l;
      end
      default: return ~s;
    endcase
  endfunction

  // Number of observed transfers that disagree with the expected write-then-read sequence.
  function automatic int trace_errors(logic [1:0] m, logic [31:0] s, int b, int n);
    int bad = 0;
    if (trace.size() != 2 * n) return 1000 + trace.size();
    for (int i = 0; i < 2 * n; i++) begin
      int idx;
      int word;
      bit wr;
      idx  = i % n;
      word = (b + idx) % 512;
      wr   = (i < n);
      if (trace[i].we !== wr || trace[i].adr !== 11'(word) ||
          (wr && trace[i].dat !== model_pat(m, s, idx, word))) bad++;
    end
    return bad;
  endfunction

  task automatic run_bist(input logic [1:0] m, input logic [31:0] s, input int b, input int n,
                          output int lat, output bit post_done, output bit post_busy);
    trace.delete();
    cyc_cnt = 0;
    @(posedge clk); #1;
    mode = m; seed = s; base = b[8:0]; len = n[9:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 6 * n + 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    @(posedge clk); #1;
    post_done = done;
    post_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({adr, cyc, stb, we, bstb, dat_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got %h want 0", {adr, cyc, stb, we, bstb, dat_o});
    end
    checks++;
    if ({busy, done, pass, tmo, errc, ferr} !== '0) begin
      errors++;
      $display("FAIL reset_status: got %h want 0", {busy, done, pass, tmo, errc, ferr});
    end
    rst = 1'b0;
  endtask

  task automatic test_const();
    int lat; bit pd, pb;
    run_bist(2'b00, 32'hFABDEFAC, 0, 4, lat, pd, pb);
    checks++;
    if (lat !== 24) begin errors++; $display("FAIL const_latency: got %0d want 24", lat); end
    checks++;
    if (trace_errors(2'b00, 32'hFABDEFAC, 0, 4) !== 0) begin
      errors++; $display("FAIL const_trace: got %0d bad transfers want 0", trace_errors(2'b00, 32'hFABDEFAC, 0, 4));
    end
    checks++;
    if ({pass, tmo, errc} !== {1'b1, 1'b0, 10'd0}) begin
      errors++; $display("FAIL const_result: got pass=%0b tmo=%0b err=%0d want 1 0 0", pass, tmo, errc);
    end
    checks++;
    if ({pd, pb} !== 2'b00) begin
      errors++; $display("FAIL const_done_pulse: got done=%0b busy=%0b want 0 0", pd, pb);
    end
  endtask

  task automatic test_lfsr_err();
    int lat; bit pd, pb;
    logic [31:0] s;
    s = $urandom;
    flip_en = 1'b1; flip_word = 9'd5;
    run_bist(2'b10, s, 0, 8, lat, pd, pb);
    flip_en = 1'b0;
    checks++;
    if (trace_errors(2'b10, s, 0, 8) !== 0 || lat !== 48) begin
      errors++; $display("FAIL lfsr_trace: got %0d bad lat=%0d want 0 bad lat=48", trace_errors(2'b10, s, 0, 8), lat);
    end
    checks++;
    if ({errc, ferr, pass} !== {10'd1, 9'd5, 1'b0}) begin
      errors++; $display("FAIL lfsr_err: got err=%0d first=%0d pass=%0b want 1 5 0", errc, ferr, pass);
    end
  endtask

  task automatic test_wrap();
    int lat; bit pd, pb;
    logic [31:0] s;
    s = $urandom;
    run_bist(2'b01, s, 510, 4, lat, pd, pb);
    checks++;
    if (trace_errors(2'b01, s, 510, 4) !== 0) begin
      errors++; $display("FAIL wrap_trace: got %0d bad transfers want 0", trace_errors(2'b01, s, 510, 4));
    end
    checks++;
    if ({pass, errc, lat} !== {1'b1, 10'd0, 32'd24}) begin
      errors++; $display("FAIL wrap_result: got pass=%0b err=%0d lat=%0d want 1 0 24", pass, errc, lat);
    end
  endtask

  task automatic test_timeout();
    int stb_cnt = 0, done_cnt = 0;
    bit cyc_at_done = 1'b1;
    bit ended = 1'b0;
    no_ack = 1'b1;
    trace.delete();
    @(posedge clk); #1;
    mode = 2'b00; seed = 32'h1234_5678; base = 9'd3; len = 10'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (stb) stb_cnt++;
      if (done) begin done_cnt++; cyc_at_done = cyc; end
      if (!busy) begin ended = 1'b1; break; end
      @(posedge clk); #1;
    end
    no_ack = 1'b0;
    checks++;
    if (stb_cnt !== 16 || !ended) begin
      errors++; $display("FAIL timeout_stb_len: got %0d cycles ended=%0b want 16 1", stb_cnt, ended);
    end
    checks++;
    if ({done_cnt, cyc_at_done} !== {32'd1, 1'b0}) begin
      errors++; $display("FAIL timeout_done: got pulses=%0d cyc=%0b want 1 0", done_cnt, cyc_at_done);
    end
    checks++;
    if ({tmo, pass, trace.size() == 0} !== 3'b101) begin
      errors++; $display("FAIL timeout_flags: got tmo=%0b pass=%0b xfers=%0d want 1 0 0", tmo, pass, trace.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit pd, pb;
    bit found = 1'b0;
    int b;
    logic [31:0] s;
    @(posedge clk); #1;
    mode = 2'b11; seed = 32'hA5A5_0F0F; base = 9'd40; len = 10'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (stb && !we) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({found, cyc, stb, busy, done} !== 5'b10000) begin
      errors++; $display("FAIL rstmid_bus: got found=%0b cyc=%0b stb=%0b busy=%0b done=%0b want 1 0 0 0 0",
                         found, cyc, stb, busy, done);
    end
    checks++;
    if ({pass, tmo, errc, ferr} !== '0) begin
      errors++; $display("FAIL rstmid_status: got %h want 0", {pass, tmo, errc, ferr});
    end
    rst = 1'b0;
    s = $urandom;
    b = $urandom_range(0, 511);
    run_bist(2'b01, s, b, 5, lat, pd, pb);
    checks++;
    if ({pass, errc, lat} !== {1'b1, 10'd0, 32'd30} || trace_errors(2'b01, s, b, 5) !== 0) begin
      errors++; $display("FAIL rstmid_rerun: got pass=%0b err=%0d lat=%0d bad=%0d want 1 0 30 0",
                         pass, errc, lat, trace_errors(2'b01, s, b, 5));
    end
  endtask

  task automatic test_len0_and_busy_start();
    int lat; bit pd, pb;
    int idle_busy = 0;
    run_bist(2'b00, 32'hDEAD_BEEF, 7, 0, lat, pd, pb);
    checks++;
    if ({lat, pass, cyc_cnt, trace.size()} !== {32'd0, 1'b1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL len0: got lat=%0d pass=%0b cyc=%0d xfers=%0d want 0 1 0 0",
                         lat, pass, cyc_cnt, trace.size());
    end
    trace.delete();
    @(posedge clk); #1;
    mode = 2'b00; seed = 32'h0BAD_F00D; base = 9'd100; len = 10'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      start = (lat == 3);
      if (lat == 3) len = 10'd9;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy) idle_busy++;
    end
    checks++;
    if ({lat, idle_busy} !== {32'd12, 32'd0} || trace_errors(2'b00, 32'h0BAD_F00D, 100, 2) !== 0) begin
      errors++; $display("FAIL busy_start: got lat=%0d rerun_cycles=%0d bad=%0d want 12 0 0",
                         lat, idle_busy, trace_errors(2'b00, 32'h0BAD_F00D, 100, 2));
    end
  endtask

  task automatic test_random();
    int lat; bit pd, pb;
    logic [1:0] m;
    logic [31:0] s;
    int b, n;
    logic [9:0] exp_err;
    logic [8:0] exp_first;
    for (int it = 0; it < 8; it++) begin
      m = (it == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      s = (it == 0) ? 32'h0 : $urandom;
      b = $urandom_range(0, 511);
      n = $urandom_range(1, 24);
      flip_en = (it != 0) && $urandom_range(0, 1) == 1;
      flip_word = 9'((b + $urandom_range(0, n - 1)) % 512);
      exp_err = flip_en ? 10'd1 : 10'd0;
      exp_first = flip_en ? flip_word : 9'd0;
      run_bist(m, s, b, n, lat, pd, pb);
      flip_en = 1'b0;
      checks++;
      if (lat !== 6 * n || trace_errors(m, s, b, n) !== 0) begin
        errors++; $display("FAIL rand%0d_trace: got lat=%0d bad=%0d want lat=%0d bad=0",
                           it, lat, trace_errors(m, s, b, n), 6 * n);
      end
      checks++;
      if ({errc, ferr, pass} !== {exp_err, exp_first, exp_err == 0}) begin
        errors++; $display("FAIL rand%0d_result: got err=%0d first=%0d pass=%0b want %0d %0d %0b",
                           it, errc, ferr, pass, exp_err, exp_first, exp_err == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_lfsr_err();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_len0_and_busy_start();
    test_random();
    checks++;
    if (proto_bad !== 0) begin
      errors++; $display("FAIL byte_strobe_protocol: got %0d bad cycles want 0", proto_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
